// File: rtl/fcs32_8_append_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fcs32_8_append_pkg
// Description : Shared constants, state encoding and CRC-32 helper functions
//               for the byte-wide Ethernet FCS appender.
// Revision    : 1.0 - initial release
// ============================================================================
package fcs32_8_append_pkg;

  localparam logic [31:0] FCS_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] FCS_POLY  = 32'h04C1_1DB7;
  localparam int          FCS_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_FCS0 = 3'd2,
    ST_FCS1 = 3'd3,
    ST_FCS2 = 3'd4,
    ST_FCS3 = 3'd5
  } fcs_state_e;

  // One byte of CRC-32, register kept MSB-first, data consumed LSB-first
  // (Ethernet bit order on the wire).
  function automatic logic [31:0] fcs32_8(input logic [7:0] d, input logic [31:0] c);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ FCS_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  // Convert the running register into the transmitted FCS word: complement
  // and reverse the bit order inside each byte, so bytes go out [31:24] first.
  function automatic logic [31:0] fcs32_brev(input logic [31:0] c);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b + i] = ~c[8*b + 7 - i];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fcs32_8_append_oreg.sv
`default_nettype none
// ============================================================================
// Module      : fcs_byte_oreg
// Description : One-deep registered output slice carrying {data, sof, eof}
//               with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fcs_byte_oreg (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_data,
  input  logic       i_val,
  output logic       o_adv,
  output logic [9:0] o_data,
  output logic       o_val,
  input  logic       i_rdy
);

  logic [9:0] r_data_q, r_data_d;
  logic       r_val_q,  r_val_d;

  assign o_adv  = !r_val_q || i_rdy;
  assign o_data = r_data_q;
  assign o_val  = r_val_q;

  // Load a new entry whenever the slot is free or being drained.
  always_comb begin
    r_data_d = r_data_q;
    r_val_d  = r_val_q;
    if (o_adv) begin
      r_val_d = i_val;
      if (i_val) r_data_d = i_data;
    end
  end

  // Output slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q <= '0;
      r_val_q  <= 1'b0;
    end else begin
      r_data_q <= r_data_d;
      r_val_q  <= r_val_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fcs32_8_append.sv
`default_nettype none
// ============================================================================
// Module      : fcs32_8_append
// Description : Byte-wide Ethernet FCS generator. Forwards payload bytes and
//               appends the 4-byte CRC-32 after the eof byte.
// Revision    : 1.0 - initial release
// ============================================================================
module fcs32_8_append
  import fcs32_8_append_pkg::*;
(
  input  logic       pclk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       sof_i,
  input  logic       eof_i,
  input  logic       val_i,
  output logic       rdy_o,
  output logic [7:0] data_o,
  output logic       sof_o,
  output logic       eof_o,
  output logic       val_o,
  input  logic       rdy_i,
  output logic       err_o
);

  fcs_state_e  r_state_q, r_state_d;
  logic [31:0] r_crc_q,   r_crc_d;
  logic        r_err_q,   r_err_d;

  logic        w_adv;
  logic        w_acc;
  logic        w_ld_val;
  logic [7:0]  w_ld_data;
  logic        w_ld_sof;
  logic        w_ld_eof;
  logic [31:0] w_fcs;
  logic [9:0]  w_oreg_out;

  assign w_fcs = fcs32_brev(r_crc_q);
  assign rdy_o = !rst_i && w_adv && ((r_state_q == ST_IDLE) || (r_state_q == ST_DATA));
  assign w_acc = val_i && rdy_o;
  assign err_o = r_err_q;

  // Next-state, CRC update and output-slot load selection.
  always_comb begin
    r_state_d = r_state_q;
    r_crc_d   = r_crc_q;
    r_err_d   = 1'b0;
    w_ld_val  = 1'b0;
    w_ld_data = 8'h00;
    w_ld_sof  = 1'b0;
    w_ld_eof  = 1'b0;
    case (r_state_q)
      ST_IDLE, ST_DATA: begin
        if (w_acc) begin
          if (sof_i) begin
            // A sof while a frame is open abandons that frame (no FCS).
            r_err_d   = (r_state_q == ST_DATA);
            w_ld_val  = 1'b1;
            w_ld_data = data_i;
            w_ld_sof  = 1'b1;
            r_crc_d   = fcs32_8(data_i, FCS_INIT);
            r_state_d = eof_i ? ST_FCS0 : ST_DATA;
          end else if (r_state_q == ST_DATA) begin
            w_ld_val  = 1'b1;
            w_ld_data = data_i;
            r_crc_d   = fcs32_8(data_i, r_crc_q);
            r_state_d = eof_i ? ST_FCS0 : ST_DATA;
          end else begin
            // Stray byte outside a frame is dropped.
            r_err_d = 1'b1;
          end
        end
      end
      ST_FCS0: if (w_adv) begin
        w_ld_val  = 1'b1;
        w_ld_data = w_fcs[31:24];
        r_state_d = ST_FCS1;
      end
      ST_FCS1: if (w_adv) begin
        w_ld_val  = 1'b1;
        w_ld_data = w_fcs[23:16];
        r_state_d = ST_FCS2;
      end
      ST_FCS2: if (w_adv) begin
        w_ld_val  = 1'b1;
        w_ld_data = w_fcs[15:8];
        r_state_d = ST_FCS3;
      end
      ST_FCS3: if (w_adv) begin
        w_ld_val  = 1'b1;
        w_ld_data = w_fcs[7:0];
        w_ld_eof  = 1'b1;
        r_state_d = ST_IDLE;
      end
      default: r_state_d = ST_IDLE;
    endcase
  end

  // Control state, CRC register and error pulse.
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      r_state_q <= ST_IDLE;
      r_crc_q   <= FCS_INIT;
      r_err_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_crc_q   <= r_crc_d;
      r_err_q   <= r_err_d;
    end
  end

  fcs_byte_oreg u_oreg (
    .clk    (pclk_i),
    .rst    (rst_i),
    .i_data ({w_ld_data, w_ld_sof, w_ld_eof}),
    .i_val  (w_ld_val),
    .o_adv  (w_adv),
    .o_data (w_oreg_out),
    .o_val  (val_o),
    .i_rdy  (rdy_i)
  );

  assign data_o = w_oreg_out[9:2];
  assign sof_o  = w_oreg_out[1];
  assign eof_o  = w_oreg_out[0];

endmodule
`default_nettype wire

// File: tb/tb_fcs32_8_append.sv
`default_nettype none
// ============================================================================
// Module      : tb_fcs32_8_append
// Description : Directed and randomized self-checking bench for the FCS
//               appender, using a reflected-CRC reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fcs32_8_append;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [9:0] ent_t;   // {sof, eof, data}

  logic       pclk_i = 1'b0;
  logic       rst_i  = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       sof_i  = 1'b0;
  logic       eof_i  = 1'b0;
  logic       val_i  = 1'b0;
  logic       rdy_o;
  logic [7:0] data_o;
  logic       sof_o;
  logic       eof_o;
  logic       val_o;
  logic       rdy_i  = 1'b1;
  logic       err_o;

  int   total = 0;
  int   bad   = 0;
  int   err_seen = 0;
  int   rdy_low  = 0;
  bit   rnd_rdy  = 1'b0;
  ent_t outq[$];
  ent_t expq[$];

  fcs32_8_append dut (
    .pclk_i (pclk_i),
    .rst_i  (rst_i),
    .data_i (data_i),
    .sof_i  (sof_i),
    .eof_i  (eof_i),
    .val_i  (val_i),
    .rdy_o  (rdy_o),
    .data_o (data_o),
    .sof_o  (sof_o),
    .eof_o  (eof_o),
    .val_o  (val_o),
    .rdy_i  (rdy_i),
    .err_o  (err_o)
  );

  always #5 pclk_i = ~pclk_i;

  // Standard reflected CRC-32 register (poly 0xEDB88320) over a byte list.
  function automatic logic [31:0] crc_reg(input byte_q_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // Expected output for a frame: payload, then ~crc sent least significant byte first.
  function automatic void add_frame(input byte_q_t b, input bit complete);
    logic [31:0] f;
    foreach (b[i]) expq.push_back({(i == 0), 1'b0, b[i]});
    if (complete) begin
      f = ~crc_reg(b);
      for (int k = 0; k < 4; k++) expq.push_back({1'b0, (k == 3), f[8*k +: 8]});
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: settle inputs, record transfers, then check stall stability.
  task automatic step(output bit acc);
    logic [10:0] held;
    bit          hold;
    if (rnd_rdy) rdy_i = 1'($urandom_range(0, 1));
    #1;
    acc  = val_i && rdy_o;
    if (val_o && rdy_i) outq.push_back({sof_o, eof_o, data_o});
    hold = val_o && !rdy_i;
    held = {val_o, sof_o, eof_o, data_o};
    if (err_o) err_seen++;
    if (!rdy_o && !rst_i) rdy_low++;
    @(posedge pclk_i);
    #1;
    if (hold) chk("stall_hold", 64'(held), 64'({val_o, sof_o, eof_o, data_o}));
  endtask

  task automatic send(input byte_q_t b, input bit with_eof);
    bit acc;
    int n;
    foreach (b[i]) begin
      data_i = b[i];
      sof_i  = (i == 0);
      eof_i  = with_eof && (i == b.size() - 1);
      val_i  = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
        step(acc);
        n++;
      end
      if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    end
    val_i = 1'b0;
    sof_i = 1'b0;
    eof_i = 1'b0;
  endtask

  task automatic drain(input int n);
    bit acc;
    int cnt = 0;
    while (outq.size() < n && cnt < 600) begin
      step(acc);
      cnt++;
    end
    rnd_rdy = 1'b0;
    rdy_i   = 1'b1;
    for (int i = 0; i < 6; i++) step(acc);
    chk("out_count", 64'(outq.size()), 64'(n));
  endtask

  task automatic compare(input string tag);
    chk({tag, "_len"}, 64'(outq.size()), 64'(expq.size()));
    foreach (expq[i]) chk(tag, 64'((i < outq.size()) ? outq[i] : 10'h3FF), 64'(expq[i]));
    outq.delete();
    expq.delete();
  endtask

  initial begin
    byte_q_t b, b2, one;
    bit      acc;
    int      e0;

    // Reset state
    rst_i = 1'b1;
    step(acc);
    step(acc);
    chk("rst_val_o", 64'(val_o), 64'd0);
    chk("rst_sof_eof", 64'({sof_o, eof_o}), 64'd0);
    chk("rst_data_o", 64'(data_o), 64'd0);
    chk("rst_err_o", 64'(err_o), 64'd0);
    chk("rst_rdy_o", 64'(rdy_o), 64'd0);
    rst_i = 1'b0;
    step(acc);
    chk("idle_rdy_o", 64'(rdy_o), 64'd1);
    outq.delete();

    // "123456789" known-answer
    b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rdy_low = 0;
    send(b, 1'b1);
    drain(13);
    chk("rdy_low_cycles", 64'(rdy_low), 64'd4);
    chk("kat_fcs", 64'({outq[9][7:0], outq[10][7:0], outq[11][7:0], outq[12][7:0]}), 64'h2639F4CB);
    chk("kat_eof_last", 64'(outq[12][8]), 64'd1);
    add_frame(b, 1'b1);
    compare("kat");

    // Single-byte frame, residue check as a downstream checker would do
    one = '{8'h00};
    send(one, 1'b1);
    drain(5);
    b2 = {};
    foreach (outq[i]) b2.push_back(outq[i][7:0]);
    chk("single_residue", 64'(crc_reg(b2)), 64'hDEBB20E3);
    chk("single_sof0", 64'(outq[0][9]), 64'd1);
    chk("single_eof4", 64'(outq[4][8]), 64'd1);
    add_frame(one, 1'b1);
    compare("single");

    // Two back-to-back random frames under random backpressure
    b = {};
    b2 = {};
    for (int i = 0; i < 64; i++) b.push_back(8'($urandom));
    for (int i = 0; i < 64; i++) b2.push_back(8'($urandom));
    rnd_rdy = 1'b1;
    send(b, 1'b1);
    send(b2, 1'b1);
    drain(136);
    add_frame(b, 1'b1);
    add_frame(b2, 1'b1);
    compare("b2b_rand");

    // Stray byte while idle
    data_i = 8'hAA;
    sof_i  = 1'b0;
    val_i  = 1'b1;
    step(acc);
    val_i  = 1'b0;
    chk("drop_err", 64'(err_o), 64'd1);
    chk("drop_val", 64'(val_o), 64'd0);
    step(acc);
    chk("drop_err_clr", 64'(err_o), 64'd0);
    chk("drop_val2", 64'(val_o), 64'd0);
    outq.delete();

    // sof inside an open frame: old frame abandoned, new one completes
    b = {};
    b2 = {};
    for (int i = 0; i < 5; i++) b.push_back(8'($urandom));
    for (int i = 0; i < 8; i++) b2.push_back(8'($urandom));
    e0 = err_seen;
    send(b, 1'b0);
    send(b2, 1'b1);
    drain(17);
    chk("abandon_err_pulses", 64'(err_seen - e0), 64'd1);
    add_frame(b, 1'b0);
    add_frame(b2, 1'b1);
    compare("abandon");

    // Reset while emitting FCS byte 1
    b = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    send(b, 1'b1);
    step(acc);
    rst_i = 1'b1;
    step(acc);
    chk("midrst_val", 64'(val_o), 64'd0);
    chk("midrst_rdy", 64'(rdy_o), 64'd0);
    rst_i = 1'b0;
    outq.delete();
    step(acc);
    chk("postrst_val", 64'(val_o), 64'd0);
    chk("postrst_rdy", 64'(rdy_o), 64'd1);
    b2 = {};
    for (int i = 0; i < 10; i++) b2.push_back(8'($urandom));
    send(b2, 1'b1);
    drain(14);
    add_frame(b2, 1'b1);
    compare("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
